mcs4_pc_stack: RTL

//   Parametrised program-counter / return-address stack unit for the next-generation MCS-4 core.

---
 rtl/mcs4_pc_stack.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mcs4_pc_stack.sv
// Program counter with a circular return-address stack, interrupt call/return
// and a nibble serializer that puts a snapshot of the PC on a 4-bit bus.
module mcs4_pc_stack #(
    parameter int          ADDR_W  = 12,
    parameter int          DEPTH   = 4,
    parameter int          PAGE_W  = 8,
    parameter logic [ADDR_W-1:0] INT_VEC = ADDR_W'('h003)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic [2:0]                cmd,
    input  logic [ADDR_W-1:0]         tgt,
    input  logic                      emit,
    input  logic                      clr_flags,
    output logic [ADDR_W-1:0]         pc,
    output logic [$clog2(DEPTH):0]    depth,
    output logic                      ovf,
    output logic                      udf,
    output logic                      int_active,
    output logic                      int_nack,
    output logic [3:0]                addr_nib,
    output logic                      nib_valid,
    output logic [(((ADDR_W/4) > 1) ? $clog2(ADDR_W/4) : 1)-1:0] nib_idx
);

    localparam int NIBS  = ADDR_W / 4;
    localparam int SLOTS = DEPTH - 1;
    localparam int SP_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int DEP_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_INC  = 3'd1,
        CMD_JUMP = 3'd2,
        CMD_PAGE = 3'd3,
        CMD_CALL = 3'd4,
        CMD_RET  = 3'd5,
        CMD_INT  = 3'd6,
        CMD_RTI  = 3'd7
    } cmd_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_e;

    logic [ADDR_W-1:0] slot [SLOTS];
    logic [SP_W-1:0]   sp, sp_inc, sp_dec;
    logic [ADDR_W-1:0] inc_pc, pc_next, call_tgt;
    logic              do_push, do_pop, int_set, int_clr, nack_next;
    logic              stack_full, stack_empty;

    // The stack pointer wraps modulo SLOTS, which need not be a power of two.
    assign inc_pc      = pc + 1'b1;
    assign sp_inc      = (sp == SP_W'(SLOTS - 1)) ? '0 : sp + 1'b1;
    assign sp_dec      = (sp == '0) ? SP_W'(SLOTS - 1) : sp - 1'b1;
    assign stack_full  = (depth == DEP_W'(SLOTS));
    assign stack_empty = (depth == '0);

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        pc_next   = pc;
        call_tgt  = tgt;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        int_set   = 1'b0;
        int_clr   = 1'b0;
        nack_next = 1'b0;
        if (cmd_valid) begin
            case (cmd_e'(cmd))
                CMD_INC:  pc_next = inc_pc;
                CMD_JUMP: pc_next = tgt;
                CMD_PAGE: pc_next = {inc_pc[ADDR_W-1:PAGE_W], tgt[PAGE_W-1:0]};
                CMD_CALL: do_push = 1'b1;
                CMD_RET:  do_pop  = 1'b1;
                CMD_INT: begin
                    if (int_active) begin
                        nack_next = 1'b1;
                    end else begin
                        do_push  = 1'b1;
                        call_tgt = INT_VEC;
                        int_set  = 1'b1;
                    end
                end
                CMD_RTI: begin
                    do_pop  = 1'b1;
                    int_clr = 1'b1;
                end
                default: ;
            endcase
        end
        if (do_push) pc_next = call_tgt;
        if (do_pop)  pc_next = slot[sp_dec];
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            sp         <= '0;
            depth      <= '0;
            ovf        <= 1'b0;
            udf        <= 1'b0;
            int_active <= 1'b0;
            int_nack   <= 1'b0;
            // NOTE: the return slots are cleared on reset because a RET on an
            // empty stack loads a stale slot, which must be deterministic.
            for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
        end else begin
            pc       <= pc_next;
            int_nack <= nack_next;
            if (do_push) begin
                slot[sp] <= inc_pc;
                sp       <= sp_inc;
                if (!stack_full) depth <= depth + 1'b1;
            end
            if (do_pop) begin
                sp <= sp_dec;
                if (!stack_empty) depth <= depth - 1'b1;
            end
            // A new error wins over a simultaneous clear.
            ovf <= (ovf & ~clr_flags) | (do_push & stack_full);
            udf <= (udf & ~clr_flags) | (do_pop & stack_empty);
            if (int_set)      int_active <= 1'b1;
            else if (int_clr) int_active <= 1'b0;
        end
    end

    ser_state_e        state, state_next;
    logic [ADDR_W-1:0] snap, snap_next;
    logic [IDX_W-1:0]  idx, idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            snap  <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            snap  <= snap_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        snap_next  = snap;
        idx_next   = idx;
        nib_valid  = 1'b0;
        addr_nib   = 4'h0;
        nib_idx    = idx;
        case (state)
            S_IDLE: begin
                if (emit) begin
                    snap_next  = pc;
                    idx_next   = '0;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                nib_valid = 1'b1;
                addr_nib  = snap[{idx, 2'b00} +: 4];
                if (idx == IDX_W'(NIBS - 1)) begin
                    idx_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
